fifo_burst_packer: RTL

- Read-side consumer of the 8-in/8-out asynchronous line FIFO (2048 deep, 12-bit read water level, no output register).
- Waits until a full burst of bytes is buffered, then pulls it with fifo_rd_en and packs PACK bytes per output word.
- Presents the words on a valid/ready stream with per-burst last and byte-keep; this stream feeds the frame-buffer write path.
- A flush request drains a partial tail at end of frame.

---
 rtl/fifo_burst_packer_pkg.sv | 28 ++
 rtl/fifo_burst_packer_out_buf.sv | 69 ++++++
 rtl/fifo_burst_packer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fifo_burst_packer_pkg.sv
// Shared types and constants for the burst packer: FSM states, default geometry
// and the byte-keep helper.
package fifo_pack_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned PACK        = 4;
    localparam int unsigned BURST_WORDS = 16;
    localparam int unsigned BB          = BURST_WORDS * PACK;
    localparam int unsigned LVL_W       = 12;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        FLUSH,
        DONE
    } state_t;

    // Mask with the low n lanes set.
    function automatic logic [PACK-1:0] keep_mask(input int unsigned n);
        logic [PACK-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < PACK; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_burst_packer_out_buf.sv
// Two-entry word FIFO carrying {data, keep, last} towards the output stream.
// Outputs read as zero whenever no word is held.
module pack_out_buf #(
    parameter int unsigned DW = 32,
    parameter int unsigned KW = 4
) (
    input  logic          clk,
    input  logic          tb_rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic [KW-1:0] push_keep_i,
    input  logic          push_last_i,
    output logic [DW-1:0] data_o,
    output logic [KW-1:0] keep_o,
    output logic          last_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [1:0]    count_o
);

    logic [DW-1:0] data_q [2];
    logic [KW-1:0] keep_q [2];
    logic [1:0]    last_q;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pop;

    assign valid_o = (cnt_q != 2'd0);
    assign pop     = valid_o && ready_i;
    assign count_o = cnt_q;
    assign data_o  = valid_o ? data_q[rd_ptr_q] : '0;
    assign keep_o  = valid_o ? keep_q[rd_ptr_q] : '0;
    assign last_o  = valid_o && last_q[rd_ptr_q];

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop;
        case ({push_i, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                keep_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                keep_q[wr_ptr_q] <= push_keep_i;
                last_q[wr_ptr_q] <= push_last_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_burst_packer.sv
// Read-side consumer of the line FIFO: pulls full bursts (or a flushed tail),
// packs bytes into words and presents them on a valid/ready stream.
module fifo_burst_packer #(
    parameter int unsigned DATA_W      = fifo_pack_pkg::DATA_W,
    parameter int unsigned PACK        = fifo_pack_pkg::PACK,
    parameter int unsigned BURST_WORDS = fifo_pack_pkg::BURST_WORDS,
    parameter int unsigned LVL_W       = fifo_pack_pkg::LVL_W
) (
    input  logic                   clk,
    input  logic                   tb_rst,
    output logic                   fifo_rd_en,
    input  logic [DATA_W-1:0]      fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LVL_W-1:0]       fifo_rd_water_level,
    input  logic                   flush,
    output logic [PACK*DATA_W-1:0] m_data,
    output logic [PACK-1:0]        m_keep,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   underflow_err
);

    import fifo_pack_pkg::*;

    localparam int unsigned      IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [LVL_W-1:0] BB_LVL = LVL_W'(BURST_WORDS * PACK);

    state_t                  state_q, state_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [LVL_W-1:0]        bytes_left_q, bytes_left_d;
    logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
    logic [PACK*DATA_W-1:0]  lanes_q, lanes_d;
    logic                    rd_pend_q, rd_last_q;
    logic                    underflow_q, underflow_d;

    logic [1:0]              buf_cnt;
    logic [1:0]              free_cnt;
    logic                    pop, push, push_last;
    logic [PACK*DATA_W-1:0]  push_data;
    logic [PACK-1:0]         push_keep;
    logic                    inflight_word, space_ok, rd_due;

    // A byte landing this cycle that closes a word occupies a buffer slot
    // before any newly issued read can, so it is reserved first.
    assign pop           = m_valid && m_ready;
    assign inflight_word = rd_pend_q && ((byte_idx_q == IDX_W'(PACK - 1)) || rd_last_q);
    assign free_cnt      = 2'd2 - buf_cnt + {1'b0, pop};
    assign space_ok      = (free_cnt > {1'b0, inflight_word});
    assign rd_due        = ((state_q == BURST) || (state_q == FLUSH))
                           && (bytes_left_q != '0) && space_ok;
    assign fifo_rd_en    = rd_due && !fifo_rd_empty;
    assign busy          = (state_q != IDLE) || (buf_cnt != 2'd0);
    assign underflow_err = underflow_q;

    always_comb begin
        lanes_d    = lanes_q;
        byte_idx_d = byte_idx_q;
        push       = 1'b0;
        push_last  = 1'b0;
        push_data  = '0;
        push_keep  = '0;
        if (rd_pend_q) begin
            lanes_d[byte_idx_q*DATA_W +: DATA_W] = fifo_rd_data;
            if (inflight_word) begin
                push       = 1'b1;
                push_last  = rd_last_q;
                push_data  = lanes_d;
                push_keep  = keep_mask(32'(byte_idx_q) + 32'd1);
                lanes_d    = '0;
                byte_idx_d = '0;
            end else begin
                byte_idx_d = byte_idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bytes_left_d = bytes_left_q;
        flush_pend_d = flush_pend_q | flush;
        underflow_d  = underflow_q;
        case (state_q)
            IDLE: begin
                if (fifo_rd_water_level >= BB_LVL) begin
                    state_d      = BURST;
                    bytes_left_d = BB_LVL;
                end else if (flush_pend_q) begin
                    flush_pend_d = flush;
                    if (fifo_rd_water_level != '0) begin
                        state_d      = FLUSH;
                        bytes_left_d = fifo_rd_water_level;
                    end
                end
            end
            BURST, FLUSH: begin
                if (fifo_rd_en) begin
                    bytes_left_d = bytes_left_q - LVL_W'(1);
                end
                if (rd_due && fifo_rd_empty) begin
                    underflow_d = 1'b1;
                end
                if (rd_pend_q && rd_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            bytes_left_q <= '0;
            byte_idx_q   <= '0;
            lanes_q      <= '0;
            rd_pend_q    <= 1'b0;
            rd_last_q    <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            bytes_left_q <= bytes_left_d;
            byte_idx_q   <= byte_idx_d;
            lanes_q      <= lanes_d;
            rd_pend_q    <= fifo_rd_en;
            rd_last_q    <= fifo_rd_en && (bytes_left_q == LVL_W'(1));
            underflow_q  <= underflow_d;
        end
    end

    pack_out_buf #(
        .DW(PACK * DATA_W),
        .KW(PACK)
    ) u_out_buf (
        .clk         (clk),
        .tb_rst      (tb_rst),
        .push_i      (push),
        .push_data_i (push_data),
        .push_keep_i (push_keep),
        .push_last_i (push_last),
        .data_o      (m_data),
        .keep_o      (m_keep),
        .last_o      (m_last),
        .valid_o     (m_valid),
        .ready_i     (m_ready),
        .count_o     (buf_cnt)
    );

endmodule
